reservoir_crossbar_lif: RTL
===========================

Name: reservoir_crossbar_lif

Overview:
Parametrised, time-stepped reservoir crossbar with leaky integrate-and-fire (LIF) neurons. Each step integrates external input events and the previous step's recurrent spikes through a programmable signed weight matrix. It then applies leak, threshold and refractory rules and publishes the new spike vector. It sits between the input encoder and the readout layer, and is the generalised successor of the fixed 16-neuron/8-input crossbar.

Parameters:
N_NEURONS, 16, reservoir neuron count
N_EXT, 8, external input channels
W_WIDTH, 8, signed weight width
V_WIDTH, 16, signed membrane/accumulator width
THRESH, 64, firing threshold (signed, V_WIDTH)
LEAK_SHIFT, 4, leak = v >>> LEAK_SHIFT per step
REFRAC, 2, refractory steps after a spike (0 = none)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low; all state cleared while low
ext_in  in  [0:N_EXT-1]  external spike events; bit 0 is the leftmost bit
step_valid  in  1  request a timestep; ext_in is sampled on acceptance
step_ready  out  1  high only in IDLE
wr_en  in  1  weight write strobe
wr_row  in  clog2(N_EXT+N_NEURONS)  presynaptic row; ext rows first, then recurrent rows
wr_col  in  clog2(N_NEURONS)  postsynaptic neuron
wr_data  in  W_WIDTH  signed weight
wr_drop  out  1  one-cycle pulse when a write is discarded
flush  in  1  synchronous clear of neuron state (weights kept)
spike_record  out  [0:N_NEURONS-1]  spikes of last completed step
spike_valid  out  1  one-cycle pulse when spike_record updates
busy  out  1  high outside IDLE

Behaviour:
- Reset (reset=0): FSM=IDLE. Clears all weights, membrane v, acc, refractory counters, prev_spikes, spike_record and spike_valid/wr_drop/busy to 0. step_ready=1 after reset is released.
- FSM states: IDLE -> ACCUM -> UPDATE -> IDLE.
- IDLE: step_valid&step_ready latches pre = {ext_in, prev_spikes}, zeroes acc[] and moves to ACCUM with row r=0.
- ACCUM: one row per cycle over r = 0..N_EXT+N_NEURONS-1. If pre[r]=1, then acc[j] += sign-extended W[r][j] for all j, with saturation to V_WIDTH. After the last row, go to UPDATE.
- UPDATE, per neuron:
  - If refrac>0: v=0, refrac-=1, no spike, and acc is discarded.
  - Otherwise: v' = sat(v - (v>>>LEAK_SHIFT) + acc). If v' >= THRESH, the neuron spikes, v=0 and refrac=REFRAC; else v=v'.
  - spike_record and prev_spikes take the new vector. spike_valid=1 for the following cycle. FSM returns to IDLE.
- Latency: spike_valid is high in cycle N_EXT+N_NEURONS+2 after the accepting edge (26 cycles at defaults). Throughput is one step per N_EXT+N_NEURONS+2 cycles.
- Writes: accepted only in IDLE and take effect the next cycle. A write in the same cycle as a step acceptance is applied before the step reads the matrix. wr_en while busy is discarded and wr_drop pulses. Writes to an out-of-range row or column are discarded with wr_drop.
- flush: highest priority in any state. It aborts any step in progress without a spike_valid pulse. It clears v, acc, refrac, prev_spikes and spike_record, and the FSM goes to IDLE the next cycle. A step_valid in the same cycle as flush is ignored.
- Saturation: signed clamp to [-2^(V_WIDTH-1), 2^(V_WIDTH-1)-1] on every add. Leak uses an arithmetic shift.
- Reset asserted mid-step: immediate clear and no output pulse.

Decomposition:
- Package reservoir_pkg holds:
  - function clog2
  - signed saturating add function sat_add(V_WIDTH)
  - state encoding typedef (IDLE/ACCUM/UPDATE)
  - default THRESH/LEAK_SHIFT constants
- One sub-module: lif_neuron. It holds per-neuron v/refrac registers and the update/threshold logic and is instantiated N_NEURONS times. The weight array, row counter and FSM stay in the top level.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release -> step_ready=1, busy=0, spike_record=0. A step with all-zero weights gives spike_valid at cycle 26 with spike_record=0.
- Direct fire: write W[0][3]=70, ext_in=8'b10000000, one step -> spike_valid 26 cycles after acceptance, spike_record bit 3 =1, all others 0.
- Leak and refractory: W[0][5]=40, ext bit 0 set each step.
  - Step 1: no spike (v=40).
  - Step 2: v=40-2+40=78, neuron 5 spikes.
  - Steps 3 and 4: neuron 5 silent (REFRAC=2).
  - Step 5: v=40, no spike.
  - Step 6: neuron 5 spikes.
- Recurrent: W[0][3]=70 and W[8+3][7]=100. Step 1 with ext bit 0 set -> neuron 3 spikes. Step 2 with ext_in=0 -> neuron 7 spikes only.
- Write while busy: wr_en mid-ACCUM -> wr_drop pulses and the weight is unchanged (read back via a subsequent step result).
- Flush mid-ACCUM at cycle 10 -> no spike_valid pulse, step_ready=1 next cycle, v cleared. A following step reproduces the step-1 results exactly.

Source files
------------

// File: rtl/reservoir_pkg.sv
// Shared types and helpers for the LIF reservoir crossbar: state encoding,
// default neuron constants, width helper and signed saturating add.
package reservoir_pkg;

    localparam int THRESH_DEF     = 64;
    localparam int LEAK_SHIFT_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    // Minimum 1 so single-entry ranges still yield a legal vector width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

    // Add two sign-extended operands and clamp to a signed range of 'width' bits.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int width);
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sum = 33'(a) + 33'(b);
        hi  = (33'sd1 <<< (width - 1)) - 33'sd1;
        lo  = -(33'sd1 <<< (width - 1));
        if (sum > hi)
            return hi[31:0];
        else if (sum < lo)
            return lo[31:0];
        else
            return sum[31:0];
    endfunction

endpackage

// File: rtl/reservoir_crossbar_lif_neuron.sv
// One leaky integrate-and-fire neuron: membrane potential, refractory counter
// and the leak/threshold decision applied when the crossbar finishes a step.
module lif_neuron
    import reservoir_pkg::*;
#(
    parameter int V_WIDTH    = 16,
    parameter int THRESH     = THRESH_DEF,
    parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
    parameter int REFRAC     = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      update,
    input  logic                      flush,
    input  logic signed [V_WIDTH-1:0] acc,
    output logic                      spike
);

    localparam int RW = (REFRAC > 0) ? clog2(REFRAC + 1) : 1;
    localparam logic signed [V_WIDTH-1:0] TH = V_WIDTH'(THRESH);
    localparam logic [RW-1:0] REFRAC_V = RW'(REFRAC);

    logic signed [V_WIDTH-1:0] v;
    logic signed [V_WIDTH-1:0] v_leak;
    logic signed [V_WIDTH-1:0] v_next;
    logic [RW-1:0]             refrac;

    always_comb begin
        v_leak = V_WIDTH'(sat_add(32'(v), -32'(v >>> LEAK_SHIFT), V_WIDTH));
        v_next = V_WIDTH'(sat_add(32'(v_leak), 32'(acc), V_WIDTH));
        spike  = (refrac == '0) && (v_next >= TH);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v      <= '0;
            refrac <= '0;
        end else if (flush) begin
            v      <= '0;
            refrac <= '0;
        end else if (update) begin
            // A refractory neuron ignores this step's input entirely.
            if (refrac != '0) begin
                v      <= '0;
                refrac <= refrac - RW'(1);
            end else if (spike) begin
                v      <= '0;
                refrac <= REFRAC_V;
            end else begin
                v      <= v_next;
            end
        end
    end

endmodule

// File: rtl/reservoir_crossbar_lif.sv
// Time-stepped reservoir crossbar: sequentially accumulates weighted input and
// recurrent spikes row by row, then updates all LIF neurons in one cycle.
module reservoir_crossbar_lif
    import reservoir_pkg::*;
#(
    parameter int N_NEURONS  = 16,
    parameter int N_EXT      = 8,
    parameter int W_WIDTH    = 8,
    parameter int V_WIDTH    = 16,
    parameter int THRESH     = THRESH_DEF,
    parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
    parameter int REFRAC     = 2
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [0:N_EXT-1]                        ext_in,
    input  logic                                    step_valid,
    output logic                                    step_ready,
    input  logic                                    wr_en,
    input  logic [clog2(N_EXT+N_NEURONS)-1:0]       wr_row,
    input  logic [clog2(N_NEURONS)-1:0]             wr_col,
    input  logic signed [W_WIDTH-1:0]               wr_data,
    output logic                                    wr_drop,
    input  logic                                    flush,
    output logic [0:N_NEURONS-1]                    spike_record,
    output logic                                    spike_valid,
    output logic                                    busy
);

    localparam int N_ROWS = N_EXT + N_NEURONS;
    localparam int ROW_W  = clog2(N_ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);

    state_t                    state_q;
    state_t                    state_d;
    logic [ROW_W-1:0]          row;
    logic [0:N_ROWS-1]         pre;
    logic signed [V_WIDTH-1:0] acc [N_NEURONS];
    logic signed [W_WIDTH-1:0] weights [N_ROWS][N_NEURONS];
    logic [0:N_NEURONS-1]      spike_next;
    logic                      wr_ok;
    logic                      do_update;

    assign step_ready = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign do_update  = (state_q == S_UPDATE) && !flush;
    assign wr_ok      = wr_en && (state_q == S_IDLE)
                        && (32'(wr_row) < N_ROWS) && (32'(wr_col) < N_NEURONS);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (step_valid) state_d = S_ACCUM;
            S_ACCUM:  if (row == LAST_ROW) state_d = S_UPDATE;
            S_UPDATE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Weight writes land on this edge, so a step accepted on the same edge
    // already sees them from its first ACCUM row.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < N_ROWS; r++)
                for (int j = 0; j < N_NEURONS; j++)
                    weights[r][j] <= '0;
        end else if (wr_ok) begin
            weights[wr_row][wr_col] <= wr_data;
        end
    end

    // spike_record doubles as the recurrent input vector for the next step.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row          <= '0;
            pre          <= '0;
            spike_record <= '0;
            spike_valid  <= 1'b0;
            wr_drop      <= 1'b0;
            for (int j = 0; j < N_NEURONS; j++) acc[j] <= '0;
        end else begin
            spike_valid <= 1'b0;
            wr_drop     <= wr_en && !wr_ok;
            if (flush) begin
                spike_record <= '0;
                for (int j = 0; j < N_NEURONS; j++) acc[j] <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (step_valid) begin
                            pre <= {ext_in, spike_record};
                            row <= '0;
                            for (int j = 0; j < N_NEURONS; j++) acc[j] <= '0;
                        end
                    end
                    S_ACCUM: begin
                        for (int j = 0; j < N_NEURONS; j++)
                            if (pre[row])
                                acc[j] <= V_WIDTH'(sat_add(32'(acc[j]),
                                                           32'(weights[row][j]),
                                                           V_WIDTH));
                        row <= row + ROW_W'(1);
                    end
                    S_UPDATE: begin
                        spike_record <= spike_next;
                        spike_valid  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < N_NEURONS; g++) begin : g_neuron
        lif_neuron #(
            .V_WIDTH    (V_WIDTH),
            .THRESH     (THRESH),
            .LEAK_SHIFT (LEAK_SHIFT),
            .REFRAC     (REFRAC)
        ) u_neuron (
            .clock  (clock),
            .reset  (reset),
            .update (do_update),
            .flush  (flush),
            .acc    (acc[g]),
            .spike  (spike_next[g])
        );
    end

endmodule
